// File: rtl/bcd2bin_serial_pkg.sv
// bcd2bin_serial_pkg
// Shared types and helpers for the serial BCD-to-binary converter.
//   state_t  : FSM encoding (ST_IDLE, ST_SHIFT)
//   bcd_w()  : width of the packed BCD input / internal accumulator
//   cnt_w()  : width of the step counter (must reach 4*DIGITS)
package bcd2bin_serial_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int          NIB_W   = 4;
    localparam logic [3:0]  NIB_MAX = 4'd9;

    function automatic int bcd_w(input int digits);
        return NIB_W * digits;
    endfunction

    function automatic int cnt_w(input int digits);
        return $clog2(NIB_W * digits + 1);
    endfunction

endpackage

// File: rtl/bcd2bin_serial_if.sv
// bcd2bin_serial_if
// Handshake/data bundle between digit-entry logic and the converter.
//   start     : request a conversion (master -> slave)
//   bcd_in    : packed BCD digits, most significant digit in top nibble
//   busy      : conversion in progress
//   done      : one-cycle result-valid pulse
//   bin_out   : low BIN_W bits of the converted value
//   ovf       : converted value does not fit in BIN_W bits
//   err_digit : a captured nibble was not a decimal digit
interface bcd2bin_serial_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  ovf;
    logic                  err_digit;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, ovf, err_digit
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, ovf, err_digit
    );
endinterface

// File: rtl/bcd2bin_serial_bcd_adj_sub3.sv
// bcd_adj_sub3
// Combinational correction cell for reverse double-dabble: after a right
// shift, a BCD digit >= 8 has received a borrowed "8" that should have been
// a "5" (half of ten), so subtract 3.
//   din  : shifted BCD digit
//   dout : corrected digit
module bcd_adj_sub3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    // din >= 8 guarantees no wrap on the subtraction
    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;
endmodule

// File: rtl/bcd2bin_serial.sv
// bcd2bin_serial
// Sequential BCD-to-binary converter, one bit per clock (reverse
// double-dabble). A valid conversion takes 4*DIGITS clocks from the accepting
// edge; an invalid digit set is rejected in one clock with err_digit.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd2bin_serial_if (start/bcd_in in,
//           busy/done/bin_out/ovf/err_digit out)
module bcd2bin_serial
    import bcd2bin_serial_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    bcd2bin_serial_if.slave   bus
);
    localparam int BCD_W = bcd_w(DIGITS);
    localparam int CNT_W = cnt_w(DIGITS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BCD_W - 1);

    state_t               state_q, state_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;

    logic [BCD_W-1:0]     bcd_shr, bcd_adj, acc_shr;
    logic [DIGITS-1:0]    nib_bad;
    logic                 any_bad;
    logic [BIN_W-1:0]     acc_lo;
    logic                 acc_ovf;

    // {bcd, acc} >> 1 : BCD LSB drops into the accumulator MSB
    assign bcd_shr = {1'b0, bcd_q[BCD_W-1:1]};
    assign acc_shr = {bcd_q[0], acc_q[BCD_W-1:1]};

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        bcd_adj_sub3 u_adj (
            .din  (bcd_shr[NIB_W*d +: NIB_W]),
            .dout (bcd_adj[NIB_W*d +: NIB_W])
        );
        assign nib_bad[d] = bus.bcd_in[NIB_W*d +: NIB_W] > NIB_MAX;
    end

    assign any_bad = |nib_bad;

    // Result is taken from the post-shift accumulator of the final step
    if (BIN_W < BCD_W) begin : g_trunc
        assign acc_lo  = acc_shr[BIN_W-1:0];
        assign acc_ovf = |acc_shr[BCD_W-1:BIN_W];
    end else begin : g_fit
        assign acc_lo  = BIN_W'(acc_shr);
        assign acc_ovf = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (any_bad) begin
                        // reject immediately; result fields reflect the error
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        bin_d  = '0;
                        ovf_d  = 1'b0;
                    end else begin
                        bcd_d   = bus.bcd_in;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_d = bcd_adj;
                acc_d = acc_shr;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    bin_d   = acc_lo;
                    ovf_d   = acc_ovf;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.done      = done_q;
    assign bus.bin_out   = bin_q;
    assign bus.ovf       = ovf_q;
    assign bus.err_digit = err_q;

endmodule

// File: doc/bcd2bin_serial.md
Name: bcd2bin_serial

Overview:
Sequential BCD-to-binary converter; the decode-direction counterpart of the binary-to-BCD display path. It takes a hundreds/tens/units digit set (e.g. from keypad or digit-entry logic) and produces the binary value using the reverse double-dabble algorithm, one bit per clock. It has a start/busy/done handshake plus error and overflow flags, and sits between user digit-entry logic and the binary datapath (counters, the 7-segment display chain).

Parameters:
DIGITS, 3, number of BCD digits converted (4*DIGITS input bits)
BIN_W, 8, width of binary result port; internal accumulator is 4*DIGITS bits

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE
bcd_in  input  4*DIGITS  packed digits, most significant digit in top nibble (centenas, dezenas, unidades for DIGITS=3)
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; result/flags valid from this cycle
bin_out  output  BIN_W  low BIN_W bits of converted value; held until next done
ovf  output  1  converted value > 2^BIN_W-1; held with bin_out
err_digit  output  1  some input nibble > 9; held with bin_out

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, bin_out=0, ovf=0, err_digit=0; internal shift register and counter cleared. Reset mid-conversion aborts with no done pulse.
- States: IDLE, SHIFT. Done is a registered pulse, not a separate state.
- IDLE, start=1 at edge k, all nibbles <= 9: capture bcd_in into the BCD register, clear the binary accumulator (4*DIGITS bits), set step counter to 0 and busy=1, then go to SHIFT.
- IDLE, start=1 at edge k, any nibble > 9: stay IDLE; after edge k, done=1, err_digit=1, bin_out=0, ovf=0. Latency is 1 cycle.
- SHIFT step, one per edge:
  - Shift the concatenation {BCD reg, accumulator} right by 1; the BCD LSB enters the accumulator MSB.
  - Then, for each digit of the shifted BCD reg, if the digit >= 8, subtract 3 (4-bit wrap-free).
- After step number 4*DIGITS, on edge k+4*DIGITS:
  - The accumulator holds the value.
  - bin_out = acc[BIN_W-1:0].
  - ovf = (acc >> BIN_W) != 0.
  - err_digit=0, done=1, busy=0, return to IDLE.
- Latency for a valid conversion: done high in the cycle after edge k+4*DIGITS (12 cycles for DIGITS=3).
- done is high for exactly one cycle and clears on the next edge unless a new invalid-digit start re-asserts it.
- start while busy=1 is ignored and not queued. start in the done cycle (state IDLE) is accepted normally.
- bcd_in is sampled only at the accepting edge; later changes have no effect.
- Counter width: clog2(4*DIGITS+1). No other arithmetic is performed on the counter.

Decomposition:
- Shared include: state encodings (ST_IDLE, ST_SHIFT) and derived constants (BCD_W = 4*DIGITS, CNT_W).
- One natural sub-module, bcd_adj_sub3: combinational 4-bit "if >= 8 subtract 3" cell, instantiated DIGITS times via generate.

Test Plan:
- bcd_in=0x255, start pulse -> busy high 12 cycles, done pulse at cycle 12, bin_out=0xFF, ovf=0, err_digit=0.
- bcd_in=0x999 -> after 12 cycles bin_out=0xE7, ovf=1; bcd_in=0x000 -> bin_out=0x00, ovf=0; bcd_in=0x128 -> bin_out=0x80.
- bcd_in=0x1A3 (invalid tens digit) -> done and err_digit high the cycle after start, bin_out=0x00, busy never asserted.
- start at 0x042, then start with 0x777 at cycle 5 while busy -> second start ignored; done at cycle 12 with bin_out=0x2A.
- rst_n low at cycle 6 of a 0x200 conversion -> all outputs 0 immediately, no done; new start with 0x017 after release -> bin_out=0x11 at 12 cycles.
- start held high continuously with 0x100 -> a conversion is accepted in each done cycle; done pulses every 13 cycles, bin_out=0x64 each time.
